gc_poller: RTL

Multi-port GameCube controller poller: the parametrised successor to the single-port controller reader. It serves NUM_PORTS open-drain joybus lines round-robin with one shared protocol engine and an optional per-port rumble request. It delivers each 64-bit status report with a one-cycle valid strobe, plus per-port connected and framing-error status. It sits between the board PMOD pins and game logic, and is clocked from the system clock.

---
 rtl/gc_poller.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/gc_poller.sv
// gc_poller: round-robin GameCube controller poller for NUM_PORTS joybus lines.
// One shared protocol engine sends the 0x4003_0R poll command to the port
// selected for the current slot, receives the 64-bit status report and
// publishes it with a one-cycle valid strobe plus connected/framing status.
// Build option: define GC_POLLER_RUMBLE_EN to send the per-port rumble bit as
// the last command bit; without it the command is always 0x400300.
module gc_poller #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned POLL_US   = 10_000
) (
    input  logic                      clk,
    input  logic                      reset,
    inout  wire  [NUM_PORTS-1:0]      data,
    input  logic [NUM_PORTS-1:0]      rumble,
    output logic [64*NUM_PORTS-1:0]   report,
    output logic [NUM_PORTS-1:0]      report_valid,
    output logic [NUM_PORTS-1:0]      connected,
    output logic [NUM_PORTS-1:0]      frame_err
);

    // Timing derived from the system clock
    localparam int unsigned US   = CLK_HZ / 1_000_000;
    localparam int unsigned SLOT = POLL_US * US / NUM_PORTS;
    localparam int unsigned SW   = $clog2(SLOT);
    localparam int unsigned PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CW   = $clog2(20 * US + 1);

    localparam logic [SW-1:0] C_SLOT_END  = SW'(SLOT - 1);
    localparam logic [PW-1:0] C_PORT_LAST = PW'(NUM_PORTS - 1);
    localparam logic [CW-1:0] C_CELL_END  = CW'(4 * US - 1);
    localparam logic [CW-1:0] C_US1       = CW'(US);
    localparam logic [CW-1:0] C_US3       = CW'(3 * US);
    localparam logic [CW-1:0] C_STOP_END  = CW'(US - 1);
    localparam logic [CW-1:0] C_SAMP      = CW'(2 * US - 1);
    localparam logic [CW-1:0] C_GAP       = CW'(8 * US - 1);
    localparam logic [CW-1:0] C_TIMEOUT   = CW'(20 * US - 1);

    localparam logic [63:0] C_NEUTRAL = 64'h0000_8080_8080_0000;
    localparam logic [6:0]  C_STOP_BIT = 7'd24;
    localparam logic [6:0]  C_RX_BITS  = 7'd64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_WAIT,
        S_RX,
        S_DONE,
        S_TIMEOUT,
        S_PARTIAL
    } state_t;

    state_t                r_state;
    logic [SW-1:0]         r_slot;
    logic [PW-1:0]         r_next_port;
    logic [PW-1:0]         r_port;
    logic [23:0]           r_tx_sr;
    logic [CW-1:0]         r_cyc;
    logic [6:0]            r_bit;
    logic [63:0]           r_shift;
    logic                  r_drive;
    logic [NUM_PORTS-1:0]  r_sync1;
    logic [NUM_PORTS-1:0]  r_sync2;
    logic [NUM_PORTS-1:0]  r_sync3;
    logic [63:0]           r_report [NUM_PORTS];
    logic [NUM_PORTS-1:0]  r_valid;
    logic [NUM_PORTS-1:0]  r_conn;
    logic [NUM_PORTS-1:0]  r_ferr;

    logic                  w_slot_start;
    logic [NUM_PORTS-1:0]  w_fall_all;
    logic                  w_fall;
    logic                  w_line;
    logic                  w_rumble_bit;
    logic [CW-1:0]         w_low_len;
    logic                  w_rx_full;
    logic                  w_rx_end;

`ifdef GC_POLLER_RUMBLE_EN
    assign w_rumble_bit = rumble[r_next_port];
`else
    // Rumble pins stay on the port list for drop-in compatibility but are forced off
    assign w_rumble_bit = rumble[r_next_port] & 1'b0;
`endif

    // Open-drain drive: only the selected port is ever pulled low
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_pin
        assign data[g] = (r_drive && (r_port == PW'(g))) ? 1'b0 : 1'bz;
    end

    assign w_slot_start = (r_slot == '0);
    assign w_fall_all   = r_sync3 & ~r_sync2;
    assign w_fall       = w_fall_all[r_port];
    assign w_line       = r_sync2[r_port];
    assign w_rx_full    = (r_bit == C_RX_BITS);
    assign w_rx_end     = w_fall || (r_cyc == C_GAP);

    // Low time of the current TX cell: short for '1' and for the stop bit
    always_comb begin
        w_low_len = C_US3;
        if ((r_bit == C_STOP_BIT) || r_tx_sr[23]) begin
            w_low_len = C_US1;
        end
    end

    // Present the per-port report registers on the flat output bus
    always_comb begin
        report = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            report[64*i +: 64] = r_report[i];
        end
    end

    assign report_valid = r_valid;
    assign connected    = r_conn;
    assign frame_err    = r_ferr;

    // Two-stage synchronizer per line plus one delay stage for falling-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_sync3 <= '1;
        end else begin
            r_sync1 <= data;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Free-running slot timer; every wrap hands the next slot to the next port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot      <= '0;
            r_next_port <= '0;
        end else begin
            if (r_slot == C_SLOT_END) begin
                r_slot <= '0;
            end else begin
                r_slot <= r_slot + 1'b1;
            end
            if (w_slot_start) begin
                if (r_next_port == C_PORT_LAST) begin
                    r_next_port <= '0;
                end else begin
                    r_next_port <= r_next_port + 1'b1;
                end
            end
        end
    end

    // Protocol engine: command transmit, response receive and status updates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_port  <= '0;
            r_tx_sr <= '0;
            r_cyc   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_drive <= 1'b0;
            r_valid <= '0;
            r_conn  <= '0;
            r_ferr  <= '0;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                r_report[i] <= C_NEUTRAL;
            end
        end else begin
            r_valid <= '0;
            r_ferr  <= '0;
            // Result outputs are written on the transition into DONE/TIMEOUT/PARTIAL,
            // so each pulse is high exactly during that one-cycle state.
            case (r_state)
                S_IDLE: begin
                    if (w_slot_start) begin
                        r_state <= S_TX;
                        r_port  <= r_next_port;
                        r_tx_sr <= {16'h4003, 7'd0, w_rumble_bit};
                        r_cyc   <= '0;
                        r_bit   <= '0;
                        r_drive <= 1'b1;
                    end
                end
                S_TX: begin
                    if ((r_bit == C_STOP_BIT) && (r_cyc == C_STOP_END)) begin
                        r_drive <= 1'b0;
                        r_cyc   <= '0;
                        r_state <= S_WAIT;
                    end else if (r_cyc == C_CELL_END) begin
                        r_cyc   <= '0;
                        r_bit   <= r_bit + 1'b1;
                        r_tx_sr <= {r_tx_sr[22:0], 1'b0};
                        r_drive <= 1'b1;
                    end else begin
                        r_cyc   <= r_cyc + 1'b1;
                        r_drive <= ((r_cyc + 1'b1) < w_low_len);
                    end
                end
                S_WAIT: begin
                    if (w_fall) begin
                        r_cyc   <= '0;
                        r_bit   <= '0;
                        r_state <= S_RX;
                    end else if (r_cyc == C_TIMEOUT) begin
                        r_report[r_port] <= C_NEUTRAL;
                        r_conn[r_port]   <= 1'b0;
                        r_state          <= S_TIMEOUT;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                S_RX: begin
                    if (w_rx_end && w_rx_full) begin
                        r_report[r_port] <= r_shift;
                        r_valid[r_port]  <= 1'b1;
                        r_conn[r_port]   <= 1'b1;
                        r_state          <= S_DONE;
                    end else if (w_fall) begin
                        r_cyc <= '0;
                    end else if (r_cyc == C_GAP) begin
                        r_ferr[r_port] <= 1'b1;
                        r_state        <= S_PARTIAL;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                        if ((r_cyc == C_SAMP) && !w_rx_full) begin
                            r_shift <= {r_shift[62:0], w_line};
                            r_bit   <= r_bit + 1'b1;
                        end
                    end
                end
                S_DONE, S_TIMEOUT, S_PARTIAL: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
